// File: rtl/idct8_pkg.sv
// idct8_pkg: shared widths and the per-sample saturation helper for the IDCT row collector.
package idct8_pkg;
    localparam int N_PTS = 8;
    localparam int IN_W  = 25;
    localparam int OUT_W = 16;
    localparam logic signed [IN_W-1:0] SAT_MAX = IN_W'((1 << (OUT_W-1)) - 1);
    localparam logic signed [IN_W-1:0] SAT_MIN = -SAT_MAX - 1;
    typedef struct packed {
        logic             clip;
        logic [OUT_W-1:0] val;
    } sat_t;
    function automatic sat_t sat_clip(input logic signed [IN_W-1:0] x);
        sat_t r;
        r.clip = (x > SAT_MAX) || (x < SAT_MIN);
        r.val  = x > SAT_MAX ? SAT_MAX[OUT_W-1:0] : x < SAT_MIN ? SAT_MIN[OUT_W-1:0] : x[OUT_W-1:0];
        return r;
    endfunction
endpackage

// File: rtl/idct8_row_fifo.sv
// idct8_row_fifo: generic show-ahead synchronous FIFO; a push into a full FIFO lands only if a pop frees a slot the same cycle.
module idct8_row_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic wr, rd;
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign rd    = pop && !empty;
    assign wr    = push && (!full || rd);
    assign dout  = empty ? '0 : mem[rp];
    always_ff @(posedge clk) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (wr) begin
                mem[wp] <= din;
                wp      <= wp + 1'b1;
            end
            if (rd) rp <= rp + 1'b1;
            count <= count + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end
endmodule

// File: rtl/idct8_row_collector.sv
// idct8_row_collector: de-skews the 8 systolic stage outputs, saturates them and queues packed rows.
module idct8_row_collector import idct8_pkg::*; #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          row_valid_in,
    input  logic signed [IN_W-1:0]        d_out_1,
    input  logic signed [IN_W-1:0]        d_out_2,
    input  logic signed [IN_W-1:0]        d_out_3,
    input  logic signed [IN_W-1:0]        d_out_4,
    input  logic signed [IN_W-1:0]        d_out_5,
    input  logic signed [IN_W-1:0]        d_out_6,
    input  logic signed [IN_W-1:0]        d_out_7,
    input  logic signed [IN_W-1:0]        d_out_8,
    output logic [N_PTS*OUT_W-1:0]        row_data,
    output logic                          row_sat,
    output logic                          row_valid,
    input  logic                          row_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    logic signed [IN_W-1:0] din [N_PTS];
    logic signed [IN_W-1:0] aligned [N_PTS];
    sat_t s [N_PTS];
    logic [N_PTS-1:1] vp;
    logic [N_PTS*OUT_W-1:0] push_data;
    logic push_sat, full, empty, pop;
    assign din = '{d_out_1, d_out_2, d_out_3, d_out_4, d_out_5, d_out_6, d_out_7, d_out_8};
    always_ff @(posedge clk) begin
        if (reset) vp <= '0;
        else vp <= {vp[N_PTS-2:1], row_valid_in};
    end
    // Stage g+1 arrives g cycles late, so it needs N_PTS-1-g delay stages to line up with the last stage.
    for (genvar g = 0; g < N_PTS-1; g++) begin : g_skew
        localparam int L = N_PTS-1-g;
        logic signed [IN_W-1:0] sr [L];
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int k = 0; k < L; k++) sr[k] <= '0;
            end else begin
                sr[0] <= din[g];
                for (int k = 1; k < L; k++) sr[k] <= sr[k-1];
            end
        end
        assign aligned[g] = sr[L-1];
    end
    assign aligned[N_PTS-1] = din[N_PTS-1];
    for (genvar g = 0; g < N_PTS; g++) begin : g_sat
        assign s[g] = sat_clip(aligned[g]);
        assign push_data[g*OUT_W +: OUT_W] = s[g].val;
    end
    always_comb begin
        push_sat = 1'b0;
        for (int i = 0; i < N_PTS; i++) push_sat = push_sat | s[i].clip;
    end
    assign row_valid = !empty;
    assign pop = row_valid && row_ready;
    idct8_row_fifo #(.WIDTH(N_PTS*OUT_W+1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (vp[N_PTS-1]),
        .pop   (pop),
        .din   ({push_sat, push_data}),
        .dout  ({row_sat, row_data}),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );
    always_ff @(posedge clk) begin
        if (reset) overflow <= 1'b0;
        else if (vp[N_PTS-1] && full && !pop) overflow <= 1'b1;
    end
endmodule

// File: tb/tb_idct8_row_collector.sv
// tb_idct8_row_collector: queue-based row model checked every cycle, plus literal spot checks.
module tb_idct8_row_collector;
    import idct8_pkg::*;
    logic clk = 0, reset = 1, row_valid_in = 0, row_ready = 0;
    logic signed [IN_W-1:0] d_out_1, d_out_2, d_out_3, d_out_4, d_out_5, d_out_6, d_out_7, d_out_8;
    logic [8*OUT_W-1:0] row_data;
    logic row_sat, row_valid, overflow;
    logic [2:0] fifo_count;

    idct8_row_collector #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .row_valid_in(row_valid_in),
        .d_out_1(d_out_1), .d_out_2(d_out_2), .d_out_3(d_out_3), .d_out_4(d_out_4),
        .d_out_5(d_out_5), .d_out_6(d_out_6), .d_out_7(d_out_7), .d_out_8(d_out_8),
        .row_data(row_data), .row_sat(row_sat), .row_valid(row_valid), .row_ready(row_ready),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0, cyc = 0;
    int rstart [64];
    int rdat [64][8];
    bit rlive [64];
    int nrows = 0;
    typedef struct {
        logic [8*OUT_W-1:0] d;
        logic s;
    } row_t;
    row_t q[$];
    bit m_ovf = 0, mp, mf;

    task automatic chk(input string n, input logic [255:0] a, input logic [255:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
        end
    endtask

    function automatic row_t expect_row(input int r);
        row_t e;
        e.d = '0;
        e.s = 0;
        for (int m = 0; m < 8; m++) begin
            int x, y;
            x = rdat[r][m];
            y = x > 32767 ? 32767 : (x < -32768 ? -32768 : x);
            e.d[m*16 +: 16] = 16'(y);
            if (y != x) e.s = 1;
        end
        return e;
    endfunction

    // Row r, started at cycle T, becomes visible at T+8 through a depth-4 queue.
    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            m_ovf = 0;
            for (int r = 0; r < nrows; r++)
                if (rstart[r] <= cyc && rstart[r] + 7 >= cyc) rlive[r] = 0;
        end else begin
            mp = q.size() > 0 && row_ready;
            mf = q.size() == 4;
            if (mp) void'(q.pop_front());
            for (int r = 0; r < nrows; r++)
                if (rlive[r] && rstart[r] + 7 == cyc) begin
                    if (!mf || mp) q.push_back(expect_row(r));
                    else m_ovf = 1;
                end
        end
        cyc++;
    end

    initial forever begin
        logic signed [IN_W-1:0] dv [8];
        logic rv;
        @(posedge clk);
        #1;
        rv = 0;
        for (int m = 0; m < 8; m++) dv[m] = IN_W'(777 + m);
        for (int r = 0; r < nrows; r++) begin
            if (rstart[r] == cyc) rv = 1;
            for (int m = 0; m < 8; m++)
                if (rstart[r] == cyc - m) dv[m] = IN_W'(rdat[r][m]);
        end
        row_valid_in = rv;
        {d_out_1, d_out_2, d_out_3, d_out_4} = {dv[0], dv[1], dv[2], dv[3]};
        {d_out_5, d_out_6, d_out_7, d_out_8} = {dv[4], dv[5], dv[6], dv[7]};
    end

    initial forever begin
        @(negedge clk);
        if (cyc >= 1) begin
            chk("row_valid", row_valid, q.size() > 0);
            chk("fifo_count", fifo_count, q.size());
            chk("overflow", overflow, m_ovf);
            if (q.size() > 0) begin
                chk("row_data", row_data, q[0].d);
                chk("row_sat", row_sat, q[0].s);
            end
        end
    end

    task automatic add_row(input int d [8]);
        rstart[nrows] = cyc + 1;
        for (int m = 0; m < 8; m++) rdat[nrows][m] = d[m];
        rlive[nrows] = 1;
        nrows++;
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(output int at);
        at = -1;
        for (int i = 0; i < 20 && at < 0; i++) begin
            @(negedge clk);
            if (row_valid) at = cyc;
        end
    endtask

    initial begin
        int t0, at, seen;
        ticks(3);
        reset = 0;
        row_ready = 1;
        // 1: single row, latency 8
        add_row('{100, 200, 300, 400, 500, 600, 700, 800});
        t0 = cyc + 1;
        wait_valid(at);
        chk("t1_latency", at, t0 + 8);
        for (int m = 0; m < 8; m++) chk($sformatf("t1_s%0d", m + 1), row_data[m*16 +: 16], 100 * (m + 1));
        chk("t1_sat", row_sat, 0);
        ticks(1);
        chk("t1_single", row_valid, 0);
        // 2: saturation
        add_row('{40000, -40000, 5, 5, 5, 5, 5, 5});
        wait_valid(at);
        chk("t2_s1", row_data[15:0], 16'h7fff);
        chk("t2_s2", row_data[31:16], 16'h8000);
        chk("t2_s3", row_data[47:32], 5);
        chk("t2_sat", row_sat, 1);
        ticks(2);
        // 3: four back-to-back rows
        for (int i = 0; i < 4; i++) begin
            add_row('{1000*(i+1)+1, 1000*(i+1)+2, 1000*(i+1)+3, 1000*(i+1)+4,
                      1000*(i+1)+5, 1000*(i+1)+6, 1000*(i+1)+7, 1000*(i+1)+8});
            if (i == 0) t0 = cyc + 1;
            ticks(1);
        end
        wait_valid(at);
        chk("t3_first", at, t0 + 8);
        for (int i = 0; i < 4; i++) begin
            chk("t3_order_s1", row_data[15:0], 1000 * (i + 1) + 1);
            chk("t3_order_s8", row_data[127:112], 1000 * (i + 1) + 8);
            ticks(1);
        end
        ticks(2);
        // 4: overflow with consumer stalled
        row_ready = 0;
        for (int i = 0; i < 5; i++) begin
            add_row('{-(i+1), 2*(i+1), 3, 4, 5, 6, 7, 8});
            ticks(1);
        end
        ticks(12);
        chk("t4_count", fifo_count, 4);
        chk("t4_overflow", overflow, 1);
        row_ready = 1;
        ticks(6);
        chk("t4_drained", row_valid, 0);
        chk("t4_sticky", overflow, 1);
        reset = 1;
        ticks(1);
        reset = 0;
        chk("t4_ovf_clr", overflow, 0);
        // 5: full FIFO, push and pop together
        row_ready = 0;
        for (int i = 0; i < 4; i++) begin
            add_row('{50+i, 1, 2, 3, 4, 5, 6, 7});
            ticks(1);
        end
        ticks(10);
        chk("t5_full", fifo_count, 4);
        add_row('{99, 1, 2, 3, 4, 5, 6, 7});
        ticks(8);
        row_ready = 1;
        ticks(1);
        row_ready = 0;
        chk("t5_count", fifo_count, 4);
        chk("t5_no_ovf", overflow, 0);
        chk("t5_head", row_data[15:0], 51);
        row_ready = 1;
        ticks(3);
        chk("t5_last", row_data[15:0], 99);
        ticks(3);
        // 6: reset mid-row
        add_row('{9, 9, 9, 9, 9, 9, 9, 9});
        ticks(5);
        reset = 1;
        ticks(1);
        reset = 0;
        chk("t6_valid0", row_valid, 0);
        chk("t6_data0", row_data, 0);
        chk("t6_sat0", row_sat, 0);
        chk("t6_count0", fifo_count, 0);
        chk("t6_ovf0", overflow, 0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            ticks(1);
            if (row_valid) seen++;
        end
        chk("t6_no_row", seen, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
